// File: rtl/add32_seq_arb.sv
// Round-robin arbitrated 32-bit add/sub unit for two requesters.
// One shared byte-wide adder with a registered carry does one byte per cycle, LSB first.
module add32_seq_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic        sub0,
    input  logic        sub1,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic [31:0] sum,
    output logic        cout,
    output logic        ovfl
);
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic        carry_q, carry_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [23:0] res_q, res_d;
    logic        last_q, last_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        done_id_q, done_id_d;
    logic [31:0] sum_q, sum_d;
    logic        cout_q, cout_d;
    logic        ovfl_q, ovfl_d;

    logic [7:0]  byte_a, byte_b;
    logic [8:0]  byte_s;
    logic        pick1, sub_sel;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovfl_d    = ovfl_q;
        pick1     = 1'b0;
        sub_sel   = 1'b0;

        byte_a = a_q[{k_q, 3'b000} +: 8];
        byte_b = b_q[{k_q, 3'b000} +: 8];
        byte_s = {1'b0, byte_a} + {1'b0, byte_b} + {8'd0, carry_q};

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // last_q holds the previous winner; on a tie the other side goes
                    pick1   = req1 && (!req0 || !last_q);
                    sub_sel = pick1 ? sub1 : sub0;
                    a_d     = pick1 ? a1 : a0;
                    b_d     = sub_sel ? ~(pick1 ? b1 : b0) : (pick1 ? b1 : b0);
                    carry_d = sub_sel;
                    k_d     = 2'd0;
                    gnt_d   = pick1 ? 2'b10 : 2'b01;
                    busy_d  = 1'b1;
                    state_d = ADD;
                end
            end
            ADD: begin
                // low bytes shift in from the top so {b2,b1,b0} sits in res_q after k=2
                res_d   = {byte_s[7:0], res_q[23:8]};
                carry_d = byte_s[8];
                k_d     = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    sum_d     = {byte_s[7:0], res_q};
                    cout_d    = byte_s[8];
                    ovfl_d    = (a_q[31] == b_q[31]) && (byte_s[7] != a_q[31]);
                    done_d    = 1'b1;
                    done_id_d = gnt_q[1];
                    state_d   = DONE;
                end
            end
            DONE: begin
                last_d    = gnt_q[1];
                gnt_d     = 2'b00;
                busy_d    = 1'b0;
                done_id_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= 2'd0;
            carry_q   <= 1'b0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            res_q     <= 24'd0;
            last_q    <= 1'b1;
            gnt_q     <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            sum_q     <= 32'd0;
            cout_q    <= 1'b0;
            ovfl_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            carry_q   <= carry_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovfl_q    <= ovfl_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign sum     = sum_q;
    assign cout    = cout_q;
    assign ovfl    = ovfl_q;
endmodule

// File: tb/tb_add32_seq_arb.sv
// Directed bench for add32_seq_arb: vector table of single operations plus
// hand-written round-robin, late-request and mid-operation reset sequences.
module tb_add32_seq_arb;
    logic        clk = 1'b0;
    logic        rst_n, req0, req1, sub0, sub1;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  gnt;
    logic        busy, done, done_id, cout, ovfl;
    logic [31:0] sum;

    int pass_cnt = 0;
    int total    = 0;

    add32_seq_arb dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sub0(sub0), .sub1(sub1),
        .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
        .sum(sum), .cout(cout), .ovfl(ovfl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r1;
        logic [31:0] a;
        logic [31:0] b;
        logic        sb;
        logic [31:0] s;
        logic        c;
        logic        o;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_gnt"}, {30'd0, gnt}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_done_id"}, {31'd0, done_id}, 32'd0);
        check({tag, "_sum"}, sum, 32'd0);
        check({tag, "_cout"}, {31'd0, cout}, 32'd0);
        check({tag, "_ovfl"}, {31'd0, ovfl}, 32'd0);
    endtask

    // Returns number of cycles until done seen (0 on timeout, which is flagged)
    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    logic [31:0] prev_sum;
    int          cyc;
    int          done_cnt;
    int          last_done;
    logic        exp_id;
    logic [31:0] exp_s;

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; sub0 = 1'b0; sub1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;

        vecs[0] = '{1'b0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};

        tick();
        tick();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);

        prev_sum = 32'd0;
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].r1) begin
                req1 = 1'b1; a1 = vecs[v].a; b1 = vecs[v].b; sub1 = vecs[v].sb;
            end else begin
                req0 = 1'b1; a0 = vecs[v].a; b0 = vecs[v].b; sub0 = vecs[v].sb;
            end
            tick();
            check($sformatf("v%0d_gnt", v), {30'd0, gnt}, vecs[v].r1 ? 32'd2 : 32'd1);
            check($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd1);
            // operands scrambled after accept must not affect the result
            req0 = 1'b0; req1 = 1'b0;
            a0 = 32'hDEADBEEF; b0 = 32'h01234567; a1 = 32'hCAFEF00D; b1 = 32'h76543210;
            sub0 = ~vecs[v].sb; sub1 = ~vecs[v].sb;
            for (int k = 1; k <= 3; k++) begin
                tick();
                check($sformatf("v%0d_t%0d_done", v, k), {31'd0, done}, 32'd0);
                check($sformatf("v%0d_t%0d_sum_hold", v, k), sum, prev_sum);
            end
            tick();
            check($sformatf("v%0d_done", v), {31'd0, done}, 32'd1);
            check($sformatf("v%0d_done_id", v), {31'd0, done_id}, {31'd0, vecs[v].r1});
            check($sformatf("v%0d_sum", v), sum, vecs[v].s);
            check($sformatf("v%0d_cout", v), {31'd0, cout}, {31'd0, vecs[v].c});
            check($sformatf("v%0d_ovfl", v), {31'd0, ovfl}, {31'd0, vecs[v].o});
            tick();
            check($sformatf("v%0d_t5_done", v), {31'd0, done}, 32'd0);
            check($sformatf("v%0d_t5_busy", v), {31'd0, busy}, 32'd0);
            check($sformatf("v%0d_t5_gnt", v), {30'd0, gnt}, 32'd0);
            check($sformatf("v%0d_t5_sum_hold", v), sum, vecs[v].s);
            prev_sum = vecs[v].s;
        end

        // Round robin: both requests held from reset release
        rst_n = 1'b0;
        tick();
        a0 = 32'd1; b0 = 32'd2; sub0 = 1'b0;
        a1 = 32'd10; b1 = 32'd3; sub1 = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        rst_n = 1'b1;
        done_cnt = 0;
        last_done = 0;
        for (int c = 1; c <= 30 && done_cnt < 4; c++) begin
            tick();
            if (done) begin
                exp_id = done_cnt[0];
                exp_s  = exp_id ? 32'd7 : 32'd3;
                check($sformatf("rr%0d_done_id", done_cnt), {31'd0, done_id}, {31'd0, exp_id});
                check($sformatf("rr%0d_sum", done_cnt), sum, exp_s);
                check($sformatf("rr%0d_spacing", done_cnt), c - last_done,
                      done_cnt == 0 ? 32'd5 : 32'd6);
                last_done = c;
                done_cnt++;
            end else if (c == last_done + 1 && done_cnt > 0) begin
                check($sformatf("rr%0d_pulse_width", done_cnt), {31'd0, done}, 32'd0);
            end else if (busy) begin
                check($sformatf("rr_c%0d_gnt", c), {30'd0, gnt}, done_cnt[0] ? 32'd2 : 32'd1);
            end
        end
        check("rr_done_count", done_cnt, 32'd4);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();
        check("rr_idle_busy", {31'd0, busy}, 32'd0);

        // req1 rises while requester 0 is being served
        req0 = 1'b1; a0 = 32'd100; b0 = 32'd23; sub0 = 1'b0;
        tick();
        req0 = 1'b0;
        req1 = 1'b1; a1 = 32'h50; b1 = 32'h5; sub1 = 1'b1;
        wait_done("late0", cyc);
        check("late0_latency", cyc, 32'd4);
        check("late0_done_id", {31'd0, done_id}, 32'd0);
        check("late0_sum", sum, 32'd123);
        tick();
        check("late_t5_gnt", {30'd0, gnt}, 32'd0);
        tick();
        check("late1_gnt", {30'd0, gnt}, 32'd2);
        req1 = 1'b0;
        wait_done("late1", cyc);
        check("late1_latency", cyc, 32'd4);
        check("late1_done_id", {31'd0, done_id}, 32'd1);
        check("late1_sum", sum, 32'h4B);
        check("late1_cout", {31'd0, cout}, 32'd1);
        tick();

        // Reset at t2 of an operation with req0 held throughout
        req0 = 1'b1; a0 = 32'h00000F0F; b0 = 32'h00000101; sub0 = 1'b0;
        tick();
        check("rst_op_gnt", {30'd0, gnt}, 32'd1);
        tick();
        check("rst_op_t1_done", {31'd0, done}, 32'd0);
        rst_n = 1'b0;
        tick();
        check_zero_outputs("midrst");
        rst_n = 1'b1;
        tick();
        check("post_rst_gnt", {30'd0, gnt}, 32'd1);
        check("post_rst_busy", {31'd0, busy}, 32'd1);
        req0 = 1'b0;
        wait_done("post_rst", cyc);
        check("post_rst_latency", cyc, 32'd4);
        check("post_rst_sum", sum, 32'h00001010);
        check("post_rst_done_id", {31'd0, done_id}, 32'd0);
        tick();
        check("post_rst_t5_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
